// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment display blocks.
package sevseg_pkg;

    localparam logic [4:0] CH_P     = 5'h10;
    localparam logic [4:0] CH_H     = 5'h11;
    localparam logic [4:0] CH_L     = 5'h12;
    localparam logic [4:0] CH_DASH  = 5'h13;
    localparam logic [4:0] CH_BLANK = 5'h1F;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef struct packed {
        logic       dp;
        logic [4:0] chr;
    } sevseg_cell_t;

    localparam sevseg_cell_t CELL_BLANK = '{dp: 1'b0, chr: CH_BLANK};

endpackage

// File: rtl/sevseg_font.sv
// Combinational character-code to segment decoder, active-high, bit0=a .. bit6=g.
// Zero latency; no handshake.
module sevseg_font
    import sevseg_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        case (i_code)
            5'h00:   o_seg = 7'h3F;
            5'h01:   o_seg = 7'h06;
            5'h02:   o_seg = 7'h5B;
            5'h03:   o_seg = 7'h4F;
            5'h04:   o_seg = 7'h66;
            5'h05:   o_seg = 7'h6D;
            5'h06:   o_seg = 7'h7D;
            5'h07:   o_seg = 7'h07;
            5'h08:   o_seg = 7'h7F;
            5'h09:   o_seg = 7'h6F;
            5'h0A:   o_seg = 7'h77;
            5'h0B:   o_seg = 7'h7C;
            5'h0C:   o_seg = 7'h39;
            5'h0D:   o_seg = 7'h5E;
            5'h0E:   o_seg = 7'h79;
            5'h0F:   o_seg = 7'h71;
            CH_P:    o_seg = 7'h73;
            CH_H:    o_seg = 7'h76;
            CH_L:    o_seg = 7'h38;
            CH_DASH: o_seg = 7'h40;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/sevseg_scan.sv
// Multiplexed seven-segment scanner with a double-buffered character store swapped at frame boundaries.
// Optional brightness PWM on sel when SEVSEG_DIM_EN is defined; writes stall (wr_ready low) while a swap is pending.
module sevseg_scan
    import sevseg_pkg::*;
#(
    parameter int  DIGITS   = 3,
    parameter int  PRESCALE = 100000,
    localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int PW       = $clog2(PRESCALE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IW-1:0]     wr_digit,
    input  logic [4:0]        wr_char,
    input  logic              wr_dp,
    input  logic              commit,
    output logic              commit_pending,
    output logic              frame_start,
`ifdef SEVSEG_DIM_EN
    input  logic [2:0]        dim_level,
`endif
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        data
);

    logic [PW-1:0]     r_presc;
    logic [IW-1:0]     r_idx;
    logic              r_pending;
    logic              r_frame_start;
    logic [DIGITS-1:0] r_sel;
    logic [7:0]        r_data;
    sevseg_cell_t      r_shadow [DIGITS];
    sevseg_cell_t      r_active [DIGITS];

    logic              w_tick;
    logic              w_last;
    logic              w_bnd;
    logic              w_wr_acc;
    logic              w_swap;
    logic [IW-1:0]     w_idx_nxt;
    logic [DIGITS-1:0] w_onehot;
    logic [DIGITS-1:0] w_sel_nxt;
    sevseg_cell_t      w_shadow_nxt [DIGITS];
    sevseg_cell_t      w_active_nxt [DIGITS];
    sevseg_cell_t      w_cell;
    logic [6:0]        w_seg;
    logic [7:0]        w_data_nxt;

    assign w_tick    = (r_presc == PW'(PRESCALE - 1));
    assign w_last    = (r_idx == IW'(DIGITS - 1));
    assign w_bnd     = w_tick && w_last;
    assign w_wr_acc  = wr_valid && !r_pending;
    // A commit landing on the boundary swaps immediately without ever raising pending.
    assign w_swap    = w_bnd && (r_pending || commit);
    assign w_idx_nxt = w_tick ? (w_last ? '0 : r_idx + IW'(1)) : r_idx;

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            w_shadow_nxt[i] = r_shadow[i];
            if (w_wr_acc && (wr_digit == IW'(i))) begin
                w_shadow_nxt[i] = '{dp: wr_dp, chr: wr_char};
            end
            w_active_nxt[i] = w_swap ? w_shadow_nxt[i] : r_active[i];
        end
    end

    // Output registers look ahead one edge so sel/data change on the tick edge itself.
    always_comb begin
        w_cell   = CELL_BLANK;
        w_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_nxt == IW'(i)) begin
                w_cell      = w_active_nxt[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    sevseg_font u_font (
        .i_code (w_cell.chr),
        .o_seg  (w_seg)
    );

    always_comb begin
        w_data_nxt         = {1'b0, w_seg};
        w_data_nxt[SEG_DP] = w_cell.dp;
    end

`ifdef SEVSEG_DIM_EN
    logic [2:0] r_pwm;
    logic [2:0] w_pwm_nxt;

    assign w_pwm_nxt = r_pwm + 3'd1;
    assign w_sel_nxt = w_onehot & {DIGITS{w_pwm_nxt <= dim_level}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 3'd0;
        end else begin
            r_pwm <= w_pwm_nxt;
        end
    end
`else
    assign w_sel_nxt = w_onehot;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
            r_sel         <= DIGITS'(1);
            r_data        <= 8'h00;
            for (int i = 0; i < DIGITS; i++) begin
                r_shadow[i] <= CELL_BLANK;
                r_active[i] <= CELL_BLANK;
            end
        end else begin
            r_presc       <= w_tick ? '0 : r_presc + PW'(1);
            r_idx         <= w_idx_nxt;
            r_frame_start <= w_bnd;
            r_sel         <= w_sel_nxt;
            r_data        <= w_data_nxt;
            r_shadow      <= w_shadow_nxt;
            r_active      <= w_active_nxt;
            if (w_bnd) begin
                r_pending <= 1'b0;
            end else if (commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign wr_ready       = !r_pending;
    assign commit_pending = r_pending;
    assign frame_start    = r_frame_start;
    assign sel            = r_sel;
    assign data           = r_data;

endmodule

// File: tb/tb_sevseg_scan.sv
// Randomized bench for sevseg_scan against a cycle-count reference model (DIGITS=4, PRESCALE=4),
// plus a small DIGITS=5 instance for out-of-range writes. Define SEVSEG_DIM_EN to cover dimming.
module tb_sevseg_scan;

    localparam int D  = 4;
    localparam int P  = 4;
    localparam int FR = D * P;

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid, wr_ready, wr_dp, commit, commit_pending, frame_start;
    logic [1:0] wr_digit;
    logic [4:0] wr_char;
    logic [3:0] sel;
    logic [7:0] data;
`ifdef SEVSEG_DIM_EN
    logic [2:0] dim_level;
    logic [2:0] m_dim;
`endif

    logic       v5, rdy5, dp5, cm5, pend5, fs5;
    logic [2:0] dig5;
    logic [4:0] ch5;
    logic [4:0] sel5;
    logic [7:0] data5;

    always #5 clk = ~clk;

    sevseg_scan #(.DIGITS(D), .PRESCALE(P)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_digit(wr_digit), .wr_char(wr_char), .wr_dp(wr_dp), .commit(commit),
        .commit_pending(commit_pending), .frame_start(frame_start),
`ifdef SEVSEG_DIM_EN
        .dim_level(dim_level),
`endif
        .sel(sel), .data(data)
    );

    sevseg_scan #(.DIGITS(5), .PRESCALE(2)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .wr_valid(v5), .wr_ready(rdy5),
        .wr_digit(dig5), .wr_char(ch5), .wr_dp(dp5), .commit(cm5),
        .commit_pending(pend5), .frame_start(fs5),
`ifdef SEVSEG_DIM_EN
        .dim_level(3'd7),
`endif
        .sel(sel5), .data(data5)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: display position follows from the cycle count since reset.
    int         m_n;
    logic       m_pend;
    logic       m_fs;
    logic [5:0] m_sh  [D];
    logic [5:0] m_act [D];

    function automatic logic [6:0] glyph(input logic [4:0] c);
        if (c < 5'h10)      return HEX[c[3:0]];
        else if (c == 5'h10) return 7'h73;
        else if (c == 5'h11) return 7'h76;
        else if (c == 5'h12) return 7'h38;
        else if (c == 5'h13) return 7'h40;
        return 7'h00;
    endfunction

    task automatic model_reset();
        m_n    = 0;
        m_pend = 1'b0;
        m_fs   = 1'b0;
        for (int i = 0; i < D; i++) begin
            m_sh[i]  = 6'h1F;
            m_act[i] = 6'h1F;
        end
    endtask

    task automatic model_edge();
        logic bnd;
        bnd = ((m_n % FR) == FR - 1);
        if (wr_valid && !m_pend) m_sh[wr_digit] = {wr_dp, wr_char};
        if (bnd) begin
            if (m_pend || commit) begin
                for (int i = 0; i < D; i++) m_act[i] = m_sh[i];
            end
            m_pend = 1'b0;
        end else if (commit) begin
            m_pend = 1'b1;
        end
        m_fs = bnd;
`ifdef SEVSEG_DIM_EN
        m_dim = dim_level;
`endif
        m_n++;
    endtask

    task automatic compare();
        int         slot;
        logic [3:0] es;
        slot = (m_n / P) % D;
        es   = 4'b0001 << slot;
`ifdef SEVSEG_DIM_EN
        if ((m_n % 8) > int'(m_dim)) es = 4'b0000;
`endif
        check("sel", sel, es);
        check("data", data, {m_act[slot][5], glyph(m_act[slot][4:0])});
        check("wr_ready", wr_ready, !m_pend);
        check("commit_pending", commit_pending, m_pend);
        check("frame_start", frame_start, m_fs);
    endtask

    task automatic cycle(input logic v, input logic [1:0] d, input logic [4:0] c,
                         input logic dp, input logic cm);
        wr_valid = v; wr_digit = d; wr_char = c; wr_dp = dp; commit = cm;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt_on, cnt_bad;
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_digit = '0; wr_char = '0; wr_dp = 1'b0; commit = 1'b0;
        v5 = 1'b0; dig5 = '0; ch5 = '0; dp5 = 1'b0; cm5 = 1'b0;
`ifdef SEVSEG_DIM_EN
        dim_level = 3'd7;
        m_dim     = 3'd7;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        check("rst_sel5", sel5, 5'b00001);
        check("rst_data5", data5, 8'h00);
        rst_n = 1'b1;

        // Free scan, then a directed write/commit sequence.
        idle(32);
        cycle(1'b1, 2'd0, 5'h05, 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 5'h0E, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 5'h10, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 5'h13, 1'b1, 1'b0);
        cycle(1'b0, 2'd0, 5'h00, 1'b0, 1'b1);
        idle(2 * FR);

        // Write and commit on the boundary edge itself.
        for (int i = 0; i < FR && (m_n % FR) != FR - 1; i++) idle(1);
        cycle(1'b1, 2'd1, 5'h11, 1'b0, 1'b1);
        idle(FR + 2);

        // A second commit and a write while pending are both ignored.
        for (int i = 0; i < FR && (m_n % FR) != 2; i++) idle(1);
        cycle(1'b0, 2'd0, 5'h00, 1'b0, 1'b1);
        cycle(1'b1, 2'd2, 5'h12, 1'b0, 1'b1);
        idle(2 * FR);

        // Out-of-range digit on the 5-digit instance is discarded.
        v5 = 1'b1; dig5 = 3'd5; ch5 = 5'h08;
        idle(1);
        dig5 = 3'd4; ch5 = 5'h01; cm5 = 1'b1;
        idle(1);
        v5 = 1'b0; cm5 = 1'b0;
        idle(20);
        cnt_on = 0; cnt_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (data5 == 8'h06) cnt_on++;
            else if (data5 != 8'h00) cnt_bad++;
            idle(1);
        end
        check("u5_digit4_cycles", cnt_on, 2);
        check("u5_stray_cells", cnt_bad, 0);
        check("u5_ready", rdy5, 1'b1);

`ifdef SEVSEG_DIM_EN
        dim_level = 3'd1;
        idle(1);
        cnt_on = 0;
        for (int i = 0; i < 16; i++) begin
            if (sel != 4'b0000) cnt_on++;
            idle(1);
        end
        check("dim1_on_cycles", cnt_on, 4);
        dim_level = 3'd7;
        idle(1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
`ifdef SEVSEG_DIM_EN
            if ($urandom_range(0, 49) == 0) dim_level = 3'($urandom);
`endif
            cycle(1'($urandom), 2'($urandom), 5'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0));
        end
        idle(2 * FR);

        // Reset mid-frame with a swap pending: the shadow must never show.
        for (int i = 0; i < FR && (m_n % FR) != 3; i++) idle(1);
        cycle(1'b1, 2'd0, 5'h08, 1'b1, 1'b0);
        cycle(1'b0, 2'd0, 5'h00, 1'b0, 1'b1);
        check("pending_before_reset", commit_pending, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
`ifdef SEVSEG_DIM_EN
        m_dim = dim_level;
`endif
        compare();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2 * FR);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
